i2c_write: RTL and testbench
============================

# i2c_write

Bit/byte-level I2C SDA transmitter for an I2C controller. It drives SDA (open-drain style) in step with an externally generated SCL and sends either a START/STOP condition or 1/8 data bits MSB-first. It reads SDA back to detect arbitration loss (write error) and illegal SDA changes while SCL is high (bus error). The upper controller FSM supplies bits serially through a load handshake.

## Interface
- Parameters: none.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  operation enable; raised while SCL is low, held until wr_finish, then dropped.
- is_data  in  1  1 = send data bits, 0 = send command.
- is_byte  in  1  data mode: 1 = 8 bits, 0 = 1 bit.
- command_i  in  1  command mode: 1 = START, 0 = STOP.
- wr_ld  out  1  one-cycle request; data_i is consumed on this edge, then the source shifts its next bit in.
- data_i  in  1  current bit to send (MSB first).
- data_o  out  1  SDA value sampled at the last SCL rising edge.
- wr_finish  out  1  level; high in DONE state.
- wr_err  out  1  write/arbitration error: drove 1, read 0 at SCL rise.
- get_start  out  1  external START seen (SDA fell while SCL high) during a data bit.
- get_stop  out  1  external STOP seen (SDA rose while SCL high) during a data bit.
- bus_err  out  1  SDA changed while SCL high during a data bit.
- scl_i  in  1  SCL line (already synchronous to clk).
- sda_i  in  1  SDA line (wired-AND result).
- sda_o  out  1  SDA drive; 1 = release, 0 = pull low.

## Operation
- Edge detect: scl_q/sda_q registers (reset 1). rise = scl_i & ~scl_q; fall = ~scl_i & scl_q; same for SDA.
- States: IDLE, LOAD, DLOW, DHIGH, CLOW, CHIGH, DONE.
- IDLE: when wr_en=1 and scl_i=0, latch is_data/is_byte/command_i, clear wr_err/bus_err/get_start/get_stop/bit counter; go LOAD if is_data, else CLOW.
- LOAD: wr_ld=1; sda_o <= data_i; go DLOW.
- DLOW: on SCL rise: data_o <= sda_i; if sda_o=1 and sda_i=0, set wr_err, sda_o <= 1 (release); go DHIGH.
- DHIGH: if SDA fall while SCL high: set bus_err and get_start; SDA rise: set bus_err and get_stop. On SCL fall: if any error flag set, or last bit (1 bit, or bit counter = 7 in byte mode), go DONE; else increment counter, go LOAD.
- CLOW: sda_o = command_i (START: 1, STOP: 0). On SCL rise: if sda_i != sda_o set wr_err; go CHIGH.
- CHIGH: first cycle sda_o <= ~command_i (START pulls low, STOP releases). Own transitions never set get_start/get_stop/bus_err. On SCL fall go DONE.
- DONE: wr_finish=1; all flags held; SCL activity ignored. Return to IDLE when wr_en=0.
- sda_o holds its last value in IDLE/DONE (START leaves SDA low, STOP leaves it released), except after wr_err in data mode, where SDA stays released.
- wr_en dropped in any busy state: return to IDLE, sda_o <= 1.

## Timing
- Reset values: sda_o=1, wr_ld=0, data_o=1, wr_finish=0, wr_err=0, bus_err=0, get_start=0, get_stop=0, state IDLE.
- First wr_ld comes 1 clk after wr_en is seen with SCL low. New bit on sda_o 2 clk after wr_en (1 clk after SCL fall for later bits).
- wr_err and data_o update in the cycle after the SCL-rise detect cycle.
- Command SDA transition: 1 clk after the SCL-rise detect cycle. SCL high phase must be ≥3 clk.
- wr_finish rises 1 clk after the final SCL fall is detected. It falls 1 clk after wr_en=0.
- Exactly 8 wr_ld pulses per error-free byte; none in command mode.

## Test plan
- START (command_i=1), SCL 4 clk low/4 clk high: sda_o=1 at rise, 0 one clk later, wr_finish after fall, no flags.
- STOP (command_i=0): sda_o=0 at rise, then 1; wr_finish; no flags.
- Single bit data_i=1 and 0, no interference: data_o equals sent bit, wr_ld pulsed once, wr_err=bus_err=0.
- Byte 0xA5, 8 SCL cycles: 8 wr_ld pulses, SDA sampled sequence 1010_0101, wr_finish after the 8th SCL fall.
- Other device pulls SDA low during a '1' bit at position k: wr_err=1, sda_o released, DONE at that bit's SCL fall, wr_finish held through remaining SCL cycles.
- SDA toggled 1 clk after SCL rise on a driven '1' bit: bus_err=1 and get_start=1 (the rise case gives get_stop=1); DONE at next SCL fall. Both errors together give wr_err=1 and bus_err=1.

Source files
------------

// File: rtl/i2c_write.sv
// i2c_write: I2C SDA transmitter sending START/STOP or 1/8 data bits in step with external SCL,
// with arbitration-loss and bus-error detection via SDA readback.
module i2c_write (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic is_data,
  input  logic is_byte,
  input  logic command_i,
  output logic wr_ld,
  input  logic data_i,
  output logic data_o,
  output logic wr_finish,
  output logic wr_err,
  output logic get_start,
  output logic get_stop,
  output logic bus_err,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o
);
  typedef enum logic [2:0] {IDLE, LOAD, DLOW, DHIGH, CLOW, CHIGH, DONE} state_t;
  state_t state_q, state_d;
  logic scl_q, sda_q, sda_o_q, sda_o_d, wr_ld_q, wr_ld_d, data_o_q, data_o_d;
  logic wr_finish_q, wr_finish_d, wr_err_q, wr_err_d, bus_err_q, bus_err_d;
  logic get_start_q, get_start_d, get_stop_q, get_stop_d;
  logic is_byte_q, is_byte_d, cmd_q, cmd_d;
  logic [2:0] cnt_q, cnt_d;
  logic scl_rise, scl_fall, sda_rise, sda_fall, busy;
  assign scl_rise = scl_i & ~scl_q;
  assign scl_fall = ~scl_i & scl_q;
  assign sda_rise = sda_i & ~sda_q;
  assign sda_fall = ~sda_i & sda_q;
  assign busy = state_q != IDLE && state_q != DONE;
  always_comb begin
    state_d = state_q;
    sda_o_d = sda_o_q;
    data_o_d = data_o_q;
    wr_err_d = wr_err_q;
    bus_err_d = bus_err_q;
    get_start_d = get_start_q;
    get_stop_d = get_stop_q;
    is_byte_d = is_byte_q;
    cmd_d = cmd_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (wr_en && !scl_i) begin
        is_byte_d = is_byte;
        cmd_d = command_i;
        {wr_err_d, bus_err_d, get_start_d, get_stop_d} = 4'b0;
        cnt_d = 3'd0;
        state_d = is_data ? LOAD : CLOW;
      end
      LOAD: begin
        sda_o_d = data_i;
        state_d = DLOW;
      end
      DLOW: if (scl_rise) begin
        data_o_d = sda_i;
        // lost arbitration: stop driving so the winner owns the bus
        if (sda_o_q && !sda_i) begin
          wr_err_d = 1'b1;
          sda_o_d = 1'b1;
        end
        state_d = DHIGH;
      end
      DHIGH: begin
        if (scl_i && sda_fall) {bus_err_d, get_start_d} = 2'b11;
        if (scl_i && sda_rise) {bus_err_d, get_stop_d} = 2'b11;
        if (scl_fall) begin
          state_d = (wr_err_q || bus_err_q || !is_byte_q || cnt_q == 3'd7) ? DONE : LOAD;
          cnt_d = cnt_q + 3'd1;
        end
      end
      CLOW: begin
        sda_o_d = cmd_q;
        if (scl_rise) begin
          wr_err_d = wr_err_q | (sda_i != sda_o_q);
          state_d = CHIGH;
        end
      end
      CHIGH: begin
        sda_o_d = ~cmd_q;
        if (scl_fall) state_d = DONE;
      end
      DONE: if (!wr_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (busy && !wr_en) begin
      state_d = IDLE;
      sda_o_d = 1'b1;
    end
    wr_ld_d = state_d == LOAD;
    wr_finish_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      {scl_q, sda_q, sda_o_q, data_o_q} <= 4'b1111;
      {wr_ld_q, wr_finish_q, wr_err_q, bus_err_q, get_start_q, get_stop_q} <= 6'b0;
      {is_byte_q, cmd_q} <= 2'b0;
      cnt_q <= 3'd0;
    end else begin
      state_q <= state_d;
      scl_q <= scl_i;
      sda_q <= sda_i;
      sda_o_q <= sda_o_d;
      data_o_q <= data_o_d;
      wr_ld_q <= wr_ld_d;
      wr_finish_q <= wr_finish_d;
      wr_err_q <= wr_err_d;
      bus_err_q <= bus_err_d;
      get_start_q <= get_start_d;
      get_stop_q <= get_stop_d;
      is_byte_q <= is_byte_d;
      cmd_q <= cmd_d;
      cnt_q <= cnt_d;
    end
  end
  assign sda_o = sda_o_q;
  assign wr_ld = wr_ld_q;
  assign data_o = data_o_q;
  assign wr_finish = wr_finish_q;
  assign wr_err = wr_err_q;
  assign bus_err = bus_err_q;
  assign get_start = get_start_q;
  assign get_stop = get_stop_q;
endmodule

// File: tb/tb_i2c_write.sv
// tb_i2c_write: scoreboard bench; expected transfer outcomes are queued at stimulus time and
// compared when the DUT signals wr_finish.
module tb_i2c_write;
  logic clk = 0, rst_n = 0, wr_en = 0, is_data = 0, is_byte = 0, command_i = 0;
  logic scl = 0, ext_low = 0;
  logic wr_ld, data_i, data_o, wr_finish, wr_err, get_start, get_stop, bus_err, sda_i, sda_o;
  logic [7:0] cur_val = 0;
  logic [2:0] ld_rel;
  logic last_do = 1'b1;
  int ld_cnt = 0, ld_base = 0, n_vec = 0, n_err = 0;
  typedef struct {
    logic [7:0] seq;
    int ld;
    logic werr, berr, gst, gsp, sda, rs;
    logic [8:0] fin;
  } exp_t;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  assign sda_i = sda_o & ~ext_low;
  assign ld_rel = 3'(ld_cnt - ld_base);
  assign data_i = cur_val[~ld_rel];
  always @(posedge clk) if (wr_ld) ld_cnt <= ld_cnt + 1;
  i2c_write dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .is_data(is_data), .is_byte(is_byte),
    .command_i(command_i), .wr_ld(wr_ld), .data_i(data_i), .data_o(data_o),
    .wr_finish(wr_finish), .wr_err(wr_err), .get_start(get_start), .get_stop(get_stop),
    .bus_err(bus_err), .scl_i(scl), .sda_i(sda_i), .sda_o(sda_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // kind: 0 clean, 1 other device holds SDA low over bit eb, 2 pulls low 1 clk after rise,
  // 3 holds low at rise and releases 1 clk after
  task automatic xfer(input logic d, input logic b, input logic c, input logic [7:0] v,
                      input int eb, input int kind);
    exp_t e, g;
    int nb, k, ncyc;
    logic smp;
    logic [7:0] gs;
    logic [8:0] gf;
    logic grs;
    e = '{default: 0};
    nb = (d && b) ? 8 : 1;
    k = nb - 1;
    for (int i = 0; i < nb; i++) begin
      smp = d ? v[7-i] : last_do;
      if (d && kind != 0 && i == eb) begin
        smp = kind == 2;
        e.werr = kind != 2;
        e.berr = kind != 1;
        e.gst = kind == 2;
        e.gsp = kind == 3;
        k = i;
      end
      e.seq[7-i] = smp;
      last_do = smp;
      if (k == i) break;
    end
    ncyc = (d && b && kind != 0) ? 8 : nb;
    for (int i = k + 1; i < ncyc; i++) e.seq[7-i] = last_do;
    e.ld = d ? k + 1 : 0;
    e.sda = !d ? ~c : (kind != 0 ? 1'b1 : v[7-k]);
    e.rs = !d ? c : v[7];
    for (int i = 0; i <= ncyc; i++) e.fin[i] = i > k;
    exp_q.push_back(e);
    @(negedge clk);
    is_data = d; is_byte = b; command_i = c; cur_val = v; ld_base = ld_cnt; scl = 0; wr_en = 1;
    gs = 0; gf = 0; grs = 0;
    for (int i = 0; i <= ncyc; i++) begin
      scl = 0;
      ext_low = d && (kind == 1 || kind == 3) && i == eb;
      repeat (2) @(negedge clk);
      gf[i] = wr_finish;
      repeat (2) @(negedge clk);
      if (i == ncyc) break;
      scl = 1;
      @(negedge clk);
      if (i == 0) grs = sda_o;
      if (d && i == eb && kind == 2) ext_low = 1;
      if (d && i == eb && kind == 3) ext_low = 0;
      @(negedge clk);
      gs[7-i] = data_o;
      repeat (2) @(negedge clk);
    end
    for (int t = 0; t < 20 && !wr_finish; t++) @(negedge clk);
    check("finish_seen", wr_finish, 1);
    if (exp_q.size() == 0) check("queue_empty", 1, 0);
    else begin
      g = exp_q.pop_front();
      check("data_o_seq", gs, g.seq);
      check("wr_ld_count", ld_cnt - ld_base, g.ld);
      check("wr_err", wr_err, g.werr);
      check("bus_err", bus_err, g.berr);
      check("get_start", get_start, g.gst);
      check("get_stop", get_stop, g.gsp);
      check("sda_o_final", sda_o, g.sda);
      check("sda_o_at_rise", grs, g.rs);
      check("finish_timing", gf, g.fin);
    end
    wr_en = 0; ext_low = 0;
    @(negedge clk);
    check("finish_drop", wr_finish, 0);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_sda_o", sda_o, 1);
    check("rst_wr_ld", wr_ld, 0);
    check("rst_data_o", data_o, 1);
    check("rst_finish", wr_finish, 0);
    check("rst_flags", {wr_err, bus_err, get_start, get_stop}, 0);
    xfer(0, 0, 1, 8'h00, 0, 0);
    xfer(0, 0, 0, 8'h00, 0, 0);
    xfer(1, 0, 0, 8'h80, 0, 0);
    xfer(1, 0, 0, 8'h00, 0, 0);
    xfer(1, 1, 0, 8'hA5, 0, 0);
    xfer(1, 1, 0, 8'h3C, 0, 0);
    xfer(1, 1, 0, 8'hA5, 2, 1);
    xfer(1, 1, 0, 8'hA5, 0, 2);
    xfer(1, 1, 0, 8'hF0, 3, 3);
    xfer(0, 0, 1, 8'h00, 0, 0);
    xfer(1, 1, 0, 8'h5A, 0, 0);
    xfer(0, 0, 0, 8'h00, 0, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    cur_val = 8'h00; ld_base = ld_cnt; is_data = 1; is_byte = 1; scl = 0; wr_en = 1;
    repeat (3) @(negedge clk);
    check("abort_drive_low", sda_o, 0);
    wr_en = 0;
    @(negedge clk);
    check("abort_release", sda_o, 1);
    check("abort_no_finish", wr_finish, 0);
    repeat (3) @(negedge clk);
    check("abort_ld_count", ld_cnt - ld_base, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
